// File: rtl/asyn_fifo_pkg.sv
// +---------------------------------------------------------------------------+
// | asyn_fifo_pkg : shared defaults and address-width helper for asyn_fifo     |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

package asyn_fifo_pkg;

    localparam int c_DEPTH_DEFAULT    = 8;
    localparam int c_DATASIZE_DEFAULT = 4;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/asyn_fifo_mem.sv
// +---------------------------------------------------------------------------+
// | asyn_fifo_mem : DEPTH x DATASIZE storage, one sync write, one sync read    |
// | Revision      : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

module asyn_fifo_mem
    import asyn_fifo_pkg::*;
#(
    parameter int DEPTH    = c_DEPTH_DEFAULT,
    parameter int DATASIZE = c_DATASIZE_DEFAULT,
    parameter int AW       = addr_width(c_DEPTH_DEFAULT)
) (
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [DATASIZE-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [DATASIZE-1:0] rd_data_o
);

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [DATASIZE-1:0] rd_data_q;

    // No reset on storage or read register; the top masks the read data until
    // the first read after reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/asyn_fifo.sv
// +---------------------------------------------------------------------------+
// | asyn_fifo : single-clock FIFO with wrap-bit pointers and registered output |
// | Optional macro ASYN_FIFO_ERR_EN adds sticky overflow/underflow outputs.    |
// | Revision  : 1.0                                                            |
// +---------------------------------------------------------------------------+
`default_nettype none

module asyn_fifo
    import asyn_fifo_pkg::*;
#(
    parameter int DEPTH    = c_DEPTH_DEFAULT,
    parameter int DATASIZE = c_DATASIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] data_in,
    output logic                full,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] data_out,
`ifdef ASYN_FIFO_ERR_EN
    output logic                overflow,
    output logic                underflow,
`endif
    output logic                empty
);

    localparam int           c_AW      = addr_width(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_AW:0]         wptr_q, wptr_d;
    logic [c_AW:0]         rptr_q, rptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [DATASIZE-1:0]   w_mem_rdata;

    // Flags come only from registered pointers, so both requests see the
    // pre-edge state: full blocks the write, empty blocks the read.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[c_AW-1:0] == rptr_q[c_AW-1:0]) && (wptr_q[c_AW] != rptr_q[c_AW]);

    assign w_wr_accept = wr_en && !full;
    assign w_rd_accept = rd_en && !empty;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_valid_d = rd_valid_q;
        if (w_wr_accept) begin
            wptr_d = wptr_q + c_PTR_ONE;
        end
        if (w_rd_accept) begin
            rptr_d     = rptr_q + c_PTR_ONE;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    asyn_fifo_mem #(
        .DEPTH    (DEPTH),
        .DATASIZE (DATASIZE),
        .AW       (c_AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_wr_accept),
        .wr_addr_i (wptr_q[c_AW-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (w_rd_accept),
        .rd_addr_i (rptr_q[c_AW-1:0]),
        .rd_data_o (w_mem_rdata)
    );

    // Read register is unreset storage; present zero until a post-reset read.
    assign data_out = rd_valid_q ? w_mem_rdata : '0;

`ifdef ASYN_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr_en && full);
        underflow_d = underflow_q || (rd_en && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_asyn_fifo.sv
// +---------------------------------------------------------------------------+
// | tb_asyn_fifo : scoreboard testbench for asyn_fifo                          |
// | Revision     : 1.0                                                         |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_asyn_fifo;

    localparam int DEPTH    = 8;
    localparam int DATASIZE = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                wr_en = 1'b0;
    logic                rd_en = 1'b0;
    logic [DATASIZE-1:0] data_in = '0;
    logic [DATASIZE-1:0] data_out;
    logic                full;
    logic                empty;
`ifdef ASYN_FIFO_ERR_EN
    logic                overflow;
    logic                underflow;
`endif

    asyn_fifo #(
        .DEPTH    (DEPTH),
        .DATASIZE (DATASIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .full      (full),
        .rd_en     (rd_en),
        .data_out  (data_out),
`ifdef ASYN_FIFO_ERR_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int                  n_cmp = 0;
    int                  n_bad = 0;
    logic [DATASIZE-1:0] sb [$];
    int                  cnt = 0;
    logic [DATASIZE-1:0] exp_dout = '0;
    logic                exp_ovf = 1'b0;
    logic                exp_unf = 1'b0;

    // Drives one clock cycle and advances the reference model; returns at #1
    // after the rising edge so outputs reflect that edge.
    task automatic drive_cycle(input logic wr, input logic rd, input logic [DATASIZE-1:0] d);
        logic w_ok, r_ok;
        wr_en   = wr;
        rd_en   = rd;
        data_in = d;
        w_ok = wr && (cnt < DEPTH);
        r_ok = rd && (cnt > 0);
        if (wr && cnt == DEPTH) exp_ovf = 1'b1;
        if (rd && cnt == 0)     exp_unf = 1'b1;
        if (r_ok) exp_dout = sb.pop_front();
        if (w_ok) sb.push_back(d);
        cnt = cnt + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        cnt      = 0;
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #100;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", data_out); end
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 10; i++) begin
            drive_cycle(1'b1, 1'b0, DATASIZE'(i));
            n_cmp++; if (full !== (cnt == DEPTH)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, cnt == DEPTH); end
            n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
            n_cmp++; if (data_out !== exp_dout) begin n_bad++; $display("FAIL fill_dout[%0d]: got %h want %h", i, data_out, exp_dout); end
        end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_final_full: got %b want 1", full); end
`ifdef ASYN_FIFO_ERR_EN
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_overflow: got %b want 1", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL fill_underflow: got %b want 0", underflow); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 12; i++) begin
            drive_cycle(1'b0, 1'b1, '0);
            n_cmp++; if (data_out !== exp_dout) begin n_bad++; $display("FAIL drain_dout[%0d]: got %h want %h", i, data_out, exp_dout); end
            n_cmp++; if (empty !== (cnt == 0)) begin n_bad++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, cnt == 0); end
            n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL drain_full[%0d]: got %b want 0", i, full); end
        end
        n_cmp++; if (data_out !== 4'h8) begin n_bad++; $display("FAIL drain_hold: got %h want 8", data_out); end
`ifdef ASYN_FIFO_ERR_EN
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL drain_underflow: got %b want 1", underflow); end
`endif
    endtask

    task automatic test_concurrent();
        logic [DATASIZE-1:0] d;
        for (int i = 0; i < 16; i++) begin
            d = DATASIZE'($urandom_range(0, (1 << DATASIZE) - 1));
            drive_cycle(1'b1, 1'b1, d);
            n_cmp++; if (data_out !== exp_dout) begin n_bad++; $display("FAIL conc_dout[%0d]: got %h want %h", i, data_out, exp_dout); end
            n_cmp++; if (empty !== (cnt == 0)) begin n_bad++; $display("FAIL conc_empty[%0d]: got %b want %b", i, empty, cnt == 0); end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, '0);
            n_cmp++; if (data_out !== exp_dout) begin n_bad++; $display("FAIL conc_tail[%0d]: got %h want %h", i, data_out, exp_dout); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL conc_final_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_both();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 1'b0, DATASIZE'(i + 3));
        end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fb_pre_full: got %b want 1", full); end
        drive_cycle(1'b1, 1'b1, 4'hF);
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL fb_full_after: got %b want 0", full); end
        n_cmp++; if (data_out !== 4'h3) begin n_bad++; $display("FAIL fb_dout: got %h want 3", data_out); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive_cycle(1'b0, 1'b1, '0);
            n_cmp++; if (data_out !== exp_dout) begin n_bad++; $display("FAIL fb_drain[%0d]: got %h want %h", i, data_out, exp_dout); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fb_final_empty: got %b want 1", empty); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, DATASIZE'(i + 1));
        end
        drive_cycle(1'b0, 1'b1, '0);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mrst_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL mrst_full: got %b want 0", full); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL mrst_dout: got %h want 0", data_out); end
`ifdef ASYN_FIFO_ERR_EN
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_bad++; $display("FAIL mrst_err: got %b%b want 00", overflow, underflow); end
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_cycle(1'b1, 1'b0, 4'hA);
        n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL mrst_wr_empty: got %b want 0", empty); end
        drive_cycle(1'b0, 1'b1, '0);
        n_cmp++; if (data_out !== 4'hA) begin n_bad++; $display("FAIL mrst_rd: got %h want a", data_out); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mrst_rd_empty: got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_concurrent();
        test_full_both();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/asyn_fifo.md
ASYN_FIFO -- requirements
Module: asyn_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of storage entries; power of two, >= 2.
REQ-002 Parameter DATASIZE, default 4, data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 wr_en  input  1  write request.
REQ-006 data_in  input  DATASIZE  write data, sampled on clk rising edge when a write is accepted.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 rd_en  input  1  read request.
REQ-009 data_out  output  DATASIZE  registered read data.
REQ-010 empty  output  1  FIFO holds zero entries.
REQ-011 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012 Write and read pointers SHALL be AW+1 bits, AW = log2(DEPTH); low AW bits address memory, MSB is wrap bit.
REQ-013 A write SHALL be accepted on a rising edge iff wr_en=1 and full=0: mem[wptr] <= data_in, wptr increments.
REQ-014 A read SHALL be accepted on a rising edge iff rd_en=1 and empty=0: data_out <= mem[rptr], rptr increments; read latency one cycle.
REQ-015 data_out SHALL hold its last value when no read is accepted.
REQ-016 empty SHALL be 1 iff wptr == rptr (all bits); full SHALL be 1 iff low AW bits equal and MSBs differ; both combinational from registered pointers.
REQ-017 wr_en while full SHALL be ignored with no state change; rd_en while empty SHALL be ignored with data_out unchanged.
REQ-018 Simultaneous accepted read and write SHALL both occur in one cycle; occupancy unchanged.
REQ-019 When full with wr_en=1 and rd_en=1, only the read SHALL occur (flags evaluated before the edge).
REQ-020 When empty with wr_en=1 and rd_en=1, only the write SHALL occur; no write-through bypass.
REQ-021 Pointers SHALL wrap modulo 2*DEPTH; data order SHALL be strict FIFO across any number of wraps.

Reset
REQ-022 While rst=0: wptr=0, rptr=0, data_out=0, empty=1, full=0, independent of clk.
REQ-023 Memory contents SHALL NOT be reset; reset mid-operation discards all stored entries.
REQ-024 Deassertion of rst SHALL take effect at the first clk rising edge after release; requests sampled then are valid.

Configuration
REQ-025 Macro ASYN_FIFO_ERR_EN, when defined, SHALL add outputs overflow and underflow (1 bit each).
REQ-026 With ASYN_FIFO_ERR_EN: overflow sets on an edge with wr_en=1 and full=1; underflow sets on an edge with rd_en=1 and empty=1; both sticky until reset, reset value 0.
REQ-027 Without ASYN_FIFO_ERR_EN the ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package asyn_fifo_pkg SHALL hold default DEPTH/DATASIZE constants and an address-width helper constant/function.
REQ-029 Storage SHALL be a sub-module asyn_fifo_mem: DEPTH x DATASIZE, one synchronous write port, one synchronous read port, no reset.
REQ-030 Top-level SHALL contain pointers, flag logic, and optional error flags.

Verification
REQ-031 Reset: hold rst=0 100 ns with toggling clk -> empty=1, full=0, data_out=0.
REQ-032 Fill: 10 write attempts of 1,2,...,10 -> first 8 accepted, full=1 after 8th, writes 9 and 10 dropped (overflow=1 if ERR_EN).
REQ-033 Drain: 12 read attempts -> data_out 1..8 in order, one cycle after each accepted read; empty=1 after 8th; 4 ignored reads leave data_out=8 (underflow=1 if ERR_EN).
REQ-034 Concurrent: 16 writes of random data with rd_en=1 throughout, starting empty -> all outputs match scoreboard order, no loss, pointers wrap at least once.
REQ-035 Full+both: at full, wr_en=rd_en=1 for one cycle -> one entry read, write dropped, full=0 after.
REQ-036 Mid-operation reset: write 5 entries, assert rst between edges -> flags reset immediately; subsequent write/read of 0xA returns 0xA.
